// File: rtl/imm_const_encoder.sv
// imm_const_encoder
//   Expands a 32-bit constant load ("li rt, value") into the shortest MIPS
//   sequence whose sign/zero-extended immediates reproduce the constant:
//   addiu, ori, lui, or a lui+ori pair. Words leave on a valid/ready stream.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : constant handshake (accepted only while idle)
//   in_value, in_rt     : constant to load and destination register
//   out_valid/out_ready : instruction-word handshake
//   out_instr           : {opcode, rs, rt, imm16}
//   out_last            : word is the final one for this constant
//   out_kind            : 0=addiu 1=ori 2=lui 3=lui+ori (held on both words)
//   word_count          : words consumed since reset, wraps modulo 2^CNT_W
module imm_const_encoder #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned USE_ZERO_FORMS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    input  logic [4:0]       in_rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_last,
    output logic [1:0]       out_kind,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_e;
    typedef enum logic [1:0] {K_ADDIU, K_ORI, K_LUI, K_PAIR} kind_e;

    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    state_e            state_q;
    kind_e             kind_q;
    logic [31:0]       instr_q;
    logic [31:0]       second_q;
    logic              valid_q;
    logic              last_q;
    logic [CNT_W-1:0]  count_q;

    // Encoding of the constant currently on the input port; only captured
    // when the handshake fires, so it is equivalent to classifying the
    // latched value.
    kind_e       enc_kind;
    logic [31:0] enc_word0;
    logic [31:0] enc_word1;
    logic        sext_ok;
    logic        zero_forms;

    always_comb begin
        zero_forms = (USE_ZERO_FORMS != 0);
        sext_ok    = (in_value[31:15] == '0) || (in_value[31:15] == '1);
        enc_kind   = K_PAIR;
        enc_word0  = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
        enc_word1  = {OP_ORI, in_rt, in_rt, in_value[15:0]};
        if (sext_ok) begin
            enc_kind  = K_ADDIU;
            enc_word0 = {OP_ADDIU, 5'd0, in_rt, in_value[15:0]};
        end else if (zero_forms && in_value[31:16] == '0) begin
            enc_kind  = K_ORI;
            enc_word0 = {OP_ORI, 5'd0, in_rt, in_value[15:0]};
        end else if (zero_forms && in_value[15:0] == '0) begin
            enc_kind  = K_LUI;
            enc_word0 = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            kind_q   <= K_ADDIU;
            instr_q  <= '0;
            second_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            if (valid_q && out_ready) begin
                count_q <= count_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q  <= EMIT1;
                        kind_q   <= enc_kind;
                        instr_q  <= enc_word0;
                        second_q <= enc_word1;
                        valid_q  <= 1'b1;
                        last_q   <= (enc_kind != K_PAIR);
                    end
                end
                EMIT1: begin
                    if (out_ready) begin
                        if (kind_q == K_PAIR) begin
                            state_q <= EMIT2;
                            instr_q <= second_q;
                            last_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                EMIT2: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = valid_q;
    assign out_instr  = instr_q;
    assign out_last   = last_q;
    assign out_kind   = kind_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_imm_const_encoder.sv
// Directed bench for imm_const_encoder: a default instance and a second
// instance without the single-word ori/lui forms and a 2-bit word counter.
module tb_imm_const_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic [1:0]  out_kind;
    logic [15:0] word_count;

    logic        nz_in_valid;
    logic        nz_in_ready;
    logic [31:0] nz_in_value;
    logic [4:0]  nz_in_rt;
    logic        nz_out_valid;
    logic        nz_out_ready;
    logic [31:0] nz_out_instr;
    logic        nz_out_last;
    logic [1:0]  nz_out_kind;
    logic [1:0]  nz_word_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_const_encoder #(.CNT_W(16), .USE_ZERO_FORMS(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_rt(in_rt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_last(out_last),
        .out_kind(out_kind), .word_count(word_count)
    );

    imm_const_encoder #(.CNT_W(2), .USE_ZERO_FORMS(0)) dut_nz (
        .clk(clk), .reset(reset),
        .in_valid(nz_in_valid), .in_ready(nz_in_ready),
        .in_value(nz_in_value), .in_rt(nz_in_rt),
        .out_valid(nz_out_valid), .out_ready(nz_out_ready),
        .out_instr(nz_out_instr), .out_last(nz_out_last),
        .out_kind(nz_out_kind), .word_count(nz_word_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic [4:0] rt);
        in_value = v;
        in_rt    = rt;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_nz(input logic [31:0] v, input logic [4:0] rt);
        nz_in_value = v;
        nz_in_rt    = rt;
        nz_in_valid = 1'b1;
        step();
        nz_in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] instr,
                               input logic last, input logic [1:0] kind);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".instr"}, out_instr, instr);
        chk({tag, ".last"},  {31'd0, out_last}, {31'd0, last});
        chk({tag, ".kind"},  {30'd0, out_kind}, {30'd0, kind});
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic expect_idle(input string tag, input logic [15:0] cnt);
        chk({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".count"}, {16'd0, word_count}, {16'd0, cnt});
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_value     = '0;
        in_rt        = '0;
        out_ready    = 1'b1;
        nz_in_valid  = 1'b0;
        nz_in_value  = '0;
        nz_in_rt     = '0;
        nz_out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset values
        chk("rst.in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_last",  {31'd0, out_last}, 32'd0);
        chk("rst.out_kind",  {30'd0, out_kind}, 32'd0);
        chk("rst.out_instr", out_instr, 32'h0000_0000);
        chk("rst.count",     {16'd0, word_count}, 32'd0);

        // Single-word forms, consumer always ready
        send(32'hFFFF_FFFF, 5'd8);
        expect_word("addiu_m1", 32'h2408_FFFF, 1'b1, 2'd0);
        step();
        expect_idle("addiu_m1", 16'd1);

        send(32'h0000_FFFF, 5'd9);
        expect_word("ori", 32'h3409_FFFF, 1'b1, 2'd1);
        step();
        expect_idle("ori", 16'd2);

        send(32'h1234_0000, 5'd10);
        expect_word("lui", 32'h3C0A_1234, 1'b1, 2'd2);
        step();
        expect_idle("lui", 16'd3);

        // Pair with back-pressure; a competing in_valid must be ignored
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd11);
        in_valid = 1'b1;
        in_value = 32'h0000_0001;
        in_rt    = 5'd3;
        for (int i = 0; i < 3; i++) begin
            expect_word("pair_stall", 32'h3C0B_1234, 1'b0, 2'd3);
            step();
        end
        in_valid = 1'b0;
        expect_word("pair_hi", 32'h3C0B_1234, 1'b0, 2'd3);
        chk("pair_hi.count", {16'd0, word_count}, 32'd3);
        out_ready = 1'b1;
        step();
        expect_word("pair_lo", 32'h356B_5678, 1'b1, 2'd3);
        chk("pair_lo.count", {16'd0, word_count}, 32'd4);
        step();
        expect_idle("pair", 16'd5);

        // Boundary constants
        send(32'h0000_7FFF, 5'd1);
        expect_word("b7fff", 32'h2401_7FFF, 1'b1, 2'd0);
        step();
        send(32'h0000_8000, 5'd1);
        expect_word("b8000", 32'h3401_8000, 1'b1, 2'd1);
        step();
        send(32'hFFFF_8000, 5'd1);
        expect_word("bffff8000", 32'h2401_8000, 1'b1, 2'd0);
        step();
        send(32'h0000_0000, 5'd0);
        expect_word("bzero_rt0", 32'h2400_0000, 1'b1, 2'd0);
        step();
        send(32'h8000_0000, 5'd1);
        expect_word("b80000000", 32'h3C01_8000, 1'b1, 2'd2);
        step();
        expect_idle("bounds", 16'd10);

        // No zero forms: ori-shaped constant becomes a pair; counter wraps at 4
        send_nz(32'h0000_FFFF, 5'd2);
        chk("nz_hi.instr", nz_out_instr, 32'h3C02_0000);
        chk("nz_hi.last",  {31'd0, nz_out_last}, 32'd0);
        chk("nz_hi.kind",  {30'd0, nz_out_kind}, 32'd3);
        step();
        chk("nz_lo.instr", nz_out_instr, 32'h3442_FFFF);
        chk("nz_lo.last",  {31'd0, nz_out_last}, 32'd1);
        chk("nz_lo.kind",  {30'd0, nz_out_kind}, 32'd3);
        step();
        chk("nz.count2", {30'd0, nz_word_count}, 32'd2);
        send_nz(32'h1234_0000, 5'd4);
        chk("nz_lui_hi.instr", nz_out_instr, 32'h3C04_1234);
        step();
        chk("nz_lui_lo.instr", nz_out_instr, 32'h3484_0000);
        step();
        chk("nz.count_wrap", {30'd0, nz_word_count}, 32'd0);
        chk("nz.idle_ready", {31'd0, nz_in_ready}, 32'd1);

        // Reset while the second word of a pair is pending
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd3);
        expect_word("rstpair_hi", 32'h3C03_1234, 1'b0, 2'd3);
        out_ready = 1'b1;
        step();
        expect_word("rstpair_lo", 32'h3463_5678, 1'b1, 2'd3);
        out_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2.out_last", {31'd0, out_last}, 32'd0);
        chk("rst2.out_kind", {30'd0, out_kind}, 32'd0);
        expect_idle("rst2", 16'd0);
        out_ready = 1'b1;
        send(32'hFFFF_8001, 5'd31);
        expect_word("post_rst", 32'h241F_8001, 1'b1, 2'd0);
        step();
        expect_idle("post_rst", 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
